// File: rtl/text_console_writer.sv
// text_console_writer: turns a byte stream into glyph writes and cursor moves for a fixed text screen.
// Define TEXT_CONSOLE_CLEAR_ON_WRAP_EN to blank each new row when the cursor advances onto it.
module text_console_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic        buffer_write_enable,
    output logic [11:0] position,
    output logic [6:0]  char_code,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col
);
    localparam int CELLS = ROWS * COLS;
    typedef enum logic [2:0] {IDLE, WRITE, STEP, CLEAR_ROW, CLEAR_ALL} state_t;
    state_t state, nxt_state;
    logic init;
    logic [7:0] byte_q, nxt_byte;
    logic [11:0] nxt_pos, cur_pos, inc_base, row_end;
    logic [6:0] nxt_code, nxt_col;
    logic [4:0] nxt_row, row_inc;
    assign row_inc = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;
    assign cur_pos = 12'(int'(cursor_row) * COLS + int'(cursor_col));
    assign inc_base = 12'(int'(row_inc) * COLS);
    assign row_end = 12'(int'(cursor_row) * COLS + COLS - 1);
    // position doubles as the clear counter while a CLEAR state is active
    always_comb begin
        nxt_state = state;
        nxt_pos = position;
        nxt_code = char_code;
        nxt_row = cursor_row;
        nxt_col = cursor_col;
        nxt_byte = byte_q;
        if (init) begin
            nxt_state = CLEAR_ALL;
            nxt_pos = 12'd0;
            nxt_code = 7'h20;
        end else begin
            case (state)
                IDLE: if (char_valid) begin
                    nxt_byte = char_in;
                    if (char_in >= 8'h20 && char_in <= 8'h7e) begin
                        nxt_state = WRITE;
                        nxt_pos = cur_pos;
                        nxt_code = char_in[6:0];
                    end else if (char_in == 8'h0c) begin
                        nxt_state = CLEAR_ALL;
                        nxt_pos = 12'd0;
                        nxt_code = 7'h20;
                    end else begin
                        nxt_state = STEP;
                    end
                end
                WRITE: begin
                    nxt_state = IDLE;
                    if (cursor_col == 7'(COLS - 1)) begin
                        nxt_col = 7'd0;
                        nxt_row = row_inc;
`ifdef TEXT_CONSOLE_CLEAR_ON_WRAP_EN
                        nxt_state = CLEAR_ROW;
                        nxt_pos = inc_base;
                        nxt_code = 7'h20;
`endif
                    end else begin
                        nxt_col = cursor_col + 7'd1;
                    end
                end
                STEP: begin
                    nxt_state = IDLE;
                    if (byte_q == 8'h0a) begin
                        nxt_col = 7'd0;
                        nxt_row = row_inc;
`ifdef TEXT_CONSOLE_CLEAR_ON_WRAP_EN
                        nxt_state = CLEAR_ROW;
                        nxt_pos = inc_base;
                        nxt_code = 7'h20;
`endif
                    end else if (byte_q == 8'h0d) begin
                        nxt_col = 7'd0;
                    end else if (byte_q == 8'h08 && cursor_col != 7'd0) begin
                        nxt_col = cursor_col - 7'd1;
                    end
                end
                CLEAR_ROW: begin
                    if (position == row_end) nxt_state = IDLE;
                    else nxt_pos = position + 12'd1;
                end
                CLEAR_ALL: begin
                    if (position == 12'(CELLS - 1)) begin
                        nxt_state = IDLE;
                        nxt_row = 5'd0;
                        nxt_col = 7'd0;
                    end else begin
                        nxt_pos = position + 12'd1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end
    // outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            init <= 1'b1;
            byte_q <= 8'd0;
            char_ready <= 1'b0;
            buffer_write_enable <= 1'b0;
            position <= 12'd0;
            char_code <= 7'd0;
            cursor_row <= 5'd0;
            cursor_col <= 7'd0;
        end else begin
            state <= nxt_state;
            init <= 1'b0;
            byte_q <= nxt_byte;
            char_ready <= (nxt_state == IDLE);
            buffer_write_enable <= (nxt_state == WRITE) || (nxt_state == CLEAR_ROW) || (nxt_state == CLEAR_ALL);
            position <= nxt_pos;
            char_code <= nxt_code;
            cursor_row <= nxt_row;
            cursor_col <= nxt_col;
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed checks of clearing, writing, cursor control and reset abort.
module tb_text_console_writer;
    logic clk = 1'b0, reset = 1'b1, char_valid = 1'b0;
    logic [7:0] char_in = 8'd0;
    logic char_ready, buffer_write_enable;
    logic [11:0] position;
    logic [6:0] char_code, cursor_col;
    logic [4:0] cursor_row;
    int vectors = 0, miscompares = 0;
    logic [11:0] wpos[$];
    logic [6:0] wcode[$];
    always #5 clk = ~clk;
    text_console_writer dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_in(char_in),
        .char_ready(char_ready), .buffer_write_enable(buffer_write_enable),
        .position(position), .char_code(char_code),
        .cursor_row(cursor_row), .cursor_col(cursor_col)
    );
    always @(posedge clk) begin
        #1;
        if (buffer_write_enable) begin
            wpos.push_back(position);
            wcode.push_back(char_code);
        end
    end
    task automatic wait_idle(input int budget);
        int n = 0;
        while (!char_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: char_ready=%b after %0d cycles, required 1", char_ready, n);
        end
    endtask
    task automatic send(input logic [7:0] b);
        wait_idle(3000);
        char_valid = 1'b1;
        char_in = b;
        @(negedge clk);
        char_valid = 1'b0;
    endtask
    task automatic check_full_clear(input string name);
        int bad = 0;
        foreach (wpos[i]) if (wpos[i] !== 12'(i) || wcode[i] !== 7'h20) bad++;
        vectors++;
        if (wpos.size() != 2400 || bad != 0) begin
            miscompares++;
            $display("FAIL %s: %0d strobes with %0d bad entries, required 2400 ascending 0x20 writes", name, wpos.size(), bad);
        end
    endtask
    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({buffer_write_enable, position, char_code, char_ready, cursor_row, cursor_col} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: we=%b pos=%0d code=%h ready=%b cur=(%0d,%0d), required all 0",
                     buffer_write_enable, position, char_code, char_ready, cursor_row, cursor_col);
        end
        wpos.delete();
        wcode.delete();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (buffer_write_enable !== 1'b1 || position !== 12'd0) begin
            miscompares++;
            $display("FAIL clear_start: we=%b pos=%0d, required we=1 pos=0", buffer_write_enable, position);
        end
        wait_idle(3000);
        check_full_clear("power_on_clear");
        vectors++;
        if (char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0 || buffer_write_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL after_clear: ready=%b we=%b cur=(%0d,%0d), required ready=1 we=0 (0,0)",
                     char_ready, buffer_write_enable, cursor_row, cursor_col);
        end
    endtask
    task automatic test_write_char;
        repeat (2) send(8'h0a);
        repeat (5) send(8'h62);
        wait_idle(200);
        vectors++;
        if (cursor_row !== 5'd2 || cursor_col !== 7'd5) begin
            miscompares++;
            $display("FAIL setup_2_5: cur=(%0d,%0d), required (2,5)", cursor_row, cursor_col);
        end
        wpos.delete();
        wcode.delete();
        send(8'h41);
        wait_idle(200);
        vectors++;
        if (wpos.size() != 1 || wpos[0] !== 12'd165 || wcode[0] !== 7'h41) begin
            miscompares++;
            $display("FAIL write_A: %0d strobes first pos=%0d code=%h, required 1 strobe pos=165 code=41",
                     wpos.size(), wpos.size() ? wpos[0] : 12'd0, wpos.size() ? wcode[0] : 7'd0);
        end
        vectors++;
        if (cursor_row !== 5'd2 || cursor_col !== 7'd6) begin
            miscompares++;
            $display("FAIL cursor_after_A: cur=(%0d,%0d), required (2,6)", cursor_row, cursor_col);
        end
    endtask
    task automatic test_wrap;
        int bad = 0;
        int want = 1;
        repeat (27) send(8'h0a);
        repeat (79) send(8'h62);
        wait_idle(200);
        vectors++;
        if (cursor_row !== 5'd29 || cursor_col !== 7'd79) begin
            miscompares++;
            $display("FAIL setup_29_79: cur=(%0d,%0d), required (29,79)", cursor_row, cursor_col);
        end
        wpos.delete();
        wcode.delete();
        send(8'h5a);
        wait_idle(200);
`ifdef TEXT_CONSOLE_CLEAR_ON_WRAP_EN
        want = 81;
        for (int i = 1; i < wpos.size(); i++) if (wpos[i] !== 12'(i - 1) || wcode[i] !== 7'h20) bad++;
`endif
        vectors++;
        if (wpos.size() != want || wpos[0] !== 12'd2399 || wcode[0] !== 7'h5a || bad != 0) begin
            miscompares++;
            $display("FAIL wrap_write: %0d strobes first pos=%0d code=%h bad=%0d, required %0d strobes first pos=2399 code=5a",
                     wpos.size(), wpos.size() ? wpos[0] : 12'd0, wpos.size() ? wcode[0] : 7'd0, bad, want);
        end
        vectors++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            miscompares++;
            $display("FAIL wrap_cursor: cur=(%0d,%0d), required (0,0)", cursor_row, cursor_col);
        end
    endtask
    task automatic test_control;
        int want = 0;
        repeat (4) send(8'h0a);
        repeat (10) send(8'h62);
        wait_idle(200);
        vectors++;
        if (cursor_row !== 5'd4 || cursor_col !== 7'd10) begin
            miscompares++;
            $display("FAIL setup_4_10: cur=(%0d,%0d), required (4,10)", cursor_row, cursor_col);
        end
        wpos.delete();
        wcode.delete();
        send(8'h0d);
        wait_idle(200);
        vectors++;
        if (cursor_row !== 5'd4 || cursor_col !== 7'd0) begin
            miscompares++;
            $display("FAIL cr: cur=(%0d,%0d), required (4,0)", cursor_row, cursor_col);
        end
        send(8'h08);
        wait_idle(200);
        vectors++;
        if (cursor_row !== 5'd4 || cursor_col !== 7'd0) begin
            miscompares++;
            $display("FAIL bs_at_col0: cur=(%0d,%0d), required (4,0)", cursor_row, cursor_col);
        end
        send(8'h0a);
        wait_idle(200);
        vectors++;
        if (cursor_row !== 5'd5 || cursor_col !== 7'd0) begin
            miscompares++;
            $display("FAIL lf: cur=(%0d,%0d), required (5,0)", cursor_row, cursor_col);
        end
`ifdef TEXT_CONSOLE_CLEAR_ON_WRAP_EN
        want = 80;
`endif
        vectors++;
        if (wpos.size() != want || (want == 80 && (wpos[0] !== 12'd400 || wpos[79] !== 12'd479))) begin
            miscompares++;
            $display("FAIL ctrl_strobes: %0d strobes, required %0d", wpos.size(), want);
        end
    endtask
    task automatic test_ignored_bytes;
        logic [7:0] bytes[2] = '{8'h07, 8'h85};
        logic [5:0] pat;
        send(8'h62);
        send(8'h08);
        wait_idle(200);
        wpos.delete();
        wcode.delete();
        foreach (bytes[k]) begin
            pat = 6'd0;
            char_valid = 1'b1;
            char_in = bytes[k];
            for (int i = 0; i < 6; i++) begin
                pat = {pat[4:0], char_ready};
                @(negedge clk);
            end
            char_valid = 1'b0;
            vectors++;
            if (pat !== 6'b101010) begin
                miscompares++;
                $display("FAIL hold_%h_ready: pattern=%b, required 101010", bytes[k], pat);
            end
        end
        wait_idle(200);
        vectors++;
        if (wpos.size() != 0 || cursor_row !== 5'd5 || cursor_col !== 7'd0) begin
            miscompares++;
            $display("FAIL ignored_effect: %0d strobes cur=(%0d,%0d), required 0 strobes (5,0)",
                     wpos.size(), cursor_row, cursor_col);
        end
    endtask
    task automatic test_abort_clear;
        int n = 0;
        int bad_we = 0;
        wpos.delete();
        wcode.delete();
        send(8'h0c);
        while (wpos.size() < 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (wpos.size() != 100 || wpos[99] !== 12'd99) begin
            miscompares++;
            $display("FAIL ff_progress: %0d strobes, required 100 ending at pos 99", wpos.size());
        end
        reset = 1'b1;
        wpos.delete();
        wcode.delete();
        repeat (3) begin
            @(negedge clk);
            if (buffer_write_enable !== 1'b0) bad_we++;
        end
        vectors++;
        if (bad_we != 0 || wpos.size() != 0) begin
            miscompares++;
            $display("FAIL reset_abort: we high %0d times, %0d strobes, required 0 and 0", bad_we, wpos.size());
        end
        reset = 1'b0;
        @(negedge clk);
        wait_idle(3000);
        check_full_clear("restart_clear");
    endtask
    initial begin
        test_reset;
        test_write_char;
        test_wrap;
        test_control;
        test_ignored_bytes;
        test_abort_clear;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
